frame_tx_scheduler: RTL and testbench
=====================================

// Module: frame_tx_scheduler
// PURPOSE
//  Round-robin scheduler that shares one 2-bit framed serial symbol line (g) among N_REQ requesters.
//  Per grant: latches the winner's payload and emits one frame: preamble, payload bits LSB-first, trailer.
//  Sits upstream of the frame decoder; its g output drives the decoder's g input directly.
//  Symbols: ZERO=2'b00, ONE=2'b01, MARK=2'b11; 2'b10 is never driven.
// PARAMETERS
//  N_REQ    4  number of requesters (>=2)
//  DATA_W   8  payload bits per frame (>=1)
//  GAP_CYC  2  ZERO symbols after trailer before returning to IDLE (0 allowed)
// PORTS
//  clk    in   1             rising-edge clock
//  reset  in   1             asynchronous, active-low reset
//  req    in   N_REQ         level request per requester
//  data   in   N_REQ*DATA_W  payload; requester i at data[i*DATA_W +: DATA_W]
//  grant  out  N_REQ         one-hot, 1-cycle pulse on first preamble cycle
//  done   out  1             1-cycle pulse, first cycle after last trailer symbol
//  busy   out  1             high in PRE/DATA/TRL/GAP
//  g      out  2             symbol line
// BEHAVIOUR
//  - Reset (async, reset=0): state=IDLE, g=00, grant=0, done=0, busy=0, rr_ptr=0, cnt=0, shreg=0.
//  - All outputs are registered or decoded from registered state only; no comb path req->g.
//  - IDLE: g=00. If |req at clock edge: pick winner, latch its data into shreg, grant<=onehot(w), cnt<=0,
//    go PRE, rr_ptr<=(w+1)%N_REQ. If no req: stay.
//  - Winner: first i with req[i]=1 scanning rr_ptr, rr_ptr+1, ... wrapping mod N_REQ.
//  - PRE, cnt 0..3: g=01,00,00,00. After cnt=3: cnt<=0, go DATA.
//  - DATA, cnt 0..DATA_W-1: g={1'b0,shreg[0]}; shreg>>=1 each cycle. After cnt=DATA_W-1: go TRL.
//  - TRL, cnt 0..3: g=11,00,00,11. After cnt=3: done<=1 for 1 cycle; go GAP (or IDLE if GAP_CYC=0).
//  - GAP: g=00 for GAP_CYC cycles, then IDLE.
//  - Frame length is DATA_W+8 cycles (16 at default).
//  - Frame start to next frame start under continuous req is DATA_W+8+GAP_CYC+1 cycles (19 at default).
//  - Payload never produces MARK, so the only MARK symbols are trailer positions 0 and 3.
//  - req is sampled only in IDLE. Requests raised or dropped while busy have no effect on the current frame.
//  - Requester may drop req or change data the cycle after grant, because payload is already latched.
//  - Simultaneous requests: exactly one grant; the others wait for a later IDLE.
//  - Reset mid-frame: frame aborted immediately, g=00, no done pulse; arbitration restarts at rr_ptr=0.
//  - cnt width: $clog2(max(DATA_W,4)). Counter never wraps within a state.
// STRUCTURE
//  - frame_link_pkg: typedef enum logic [2:0] {IDLE,PRE,DATA,TRL,GAP} tx_state_t.
//  - frame_link_pkg: localparams SYM_ZERO, SYM_ONE, SYM_MARK.
//  - frame_link_pkg: PREAMBLE[4]={01,00,00,00} and TRAILER[4]={11,00,00,11}.
//  - One sub-module, rr_arbiter #(N): comb winner select from req and rr_ptr, outputs onehot and index.
//  - rr_ptr register lives in the parent.
//  - Parent holds FSM, cnt, shreg, and output registers.
// TESTING (N_REQ=4, DATA_W=8, GAP_CYC=2; cycle 1 = first PRE cycle)
//  1. Reset, req=0 for 50 cycles -> g=00, busy=0, grant=0, done=0 throughout.
//  2. req=0100, data[2]=8'hA5 -> grant=0100 at cycle 1 only.
//     g for cycles 1-16: 01,00,00,00, 01,00,01,00,00,01,00,01, 11,00,00,11.
//     done=1 at cycle 17; busy low from cycle 19.
//  3. req=1111 held -> grants 0001,0010,0100,1000,0001 with frame starts 19 cycles apart.
//  4. req=0001 frame running; raise req=0010 at cycle 5, drop req[0] -> no grant until IDLE; next grant=0010 at cycle 20.
//  5. reset low during DATA (cycle 8) -> g=00, busy=0 same cycle, no done pulse.
//     Release with req=1000 held -> grant=1000 (ptr restarts at 0).
//  6. data=8'h00 then 8'hFF -> DATA g all 00, then all 01; g==11 only at trailer positions 0 and 3.

Source files
------------

// File: rtl/frame_link_pkg.sv
// frame_link_pkg: shared FSM states, line symbols and frame framing patterns
// for the framed 2-bit symbol link.
package frame_link_pkg;
   typedef enum logic [2:0] {IDLE, PRE, DATA, TRL, GAP} tx_state_t;
   localparam logic [1:0] SYM_ZERO = 2'b00;
   localparam logic [1:0] SYM_ONE  = 2'b01;
   localparam logic [1:0] SYM_MARK = 2'b11;
   localparam logic [1:0] PREAMBLE [4] = '{SYM_ONE, SYM_ZERO, SYM_ZERO, SYM_ZERO};
   localparam logic [1:0] TRAILER  [4] = '{SYM_MARK, SYM_ZERO, SYM_ZERO, SYM_MARK};
   // The counter is also reused for the gap phase, so size it for that too.
   function automatic int cnt_width(input int dw, input int gap);
      int m;
      m = (dw > 4) ? dw : 4;
      m = (gap > m) ? gap : m;
      return $clog2(m);
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin winner select; the first requester
// at or after i_ptr (wrapping) wins.
module rr_arbiter #(
   parameter int N = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_onehot,
   output logic [IW-1:0] o_idx,
   output logic          o_valid
);
   logic [IW-1:0] w_j;
   // Scan from the farthest offset back to i_ptr so the nearest hit is written last.
   always_comb begin
      o_idx   = '0;
      o_valid = 1'b0;
      w_j     = '0;
      for (int k = N - 1; k >= 0; k--) begin
         w_j = IW'((int'(i_ptr) + k) % N);
         if (i_req[w_j]) begin
            o_idx   = w_j;
            o_valid = 1'b1;
         end
      end
   end
   assign o_onehot = o_valid ? N'(1) << o_idx : '0;
endmodule

// File: rtl/frame_tx_scheduler.sv
// frame_tx_scheduler: round-robin scheduler granting one requester at a time
// and emitting its payload as a preamble/LSB-first data/trailer symbol frame.
module frame_tx_scheduler
   import frame_link_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int DATA_W  = 8,
   parameter int GAP_CYC = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ*DATA_W-1:0]   data,
   output logic [N_REQ-1:0]          grant,
   output logic                      done,
   output logic                      busy,
   output logic [1:0]                g
);
   localparam int IW    = $clog2(N_REQ);
   localparam int CNT_W = cnt_width(DATA_W, GAP_CYC);
   localparam logic [CNT_W-1:0] LAST_4 = CNT_W'(3);
   localparam logic [CNT_W-1:0] LAST_D = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] LAST_G = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

   tx_state_t        r_state, w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [DATA_W-1:0] r_shreg;
   logic [IW-1:0]    r_rr_ptr, w_idx;
   logic [N_REQ-1:0] r_grant, w_onehot;
   logic             r_done, w_valid, w_last;

   rr_arbiter #(.N(N_REQ)) u_arb (
      .i_req    (req),
      .i_ptr    (r_rr_ptr),
      .o_onehot (w_onehot),
      .o_idx    (w_idx),
      .o_valid  (w_valid)
   );

   always_comb
      w_last = (r_state == PRE || r_state == TRL) ? r_cnt == LAST_4 :
               (r_state == DATA) ? r_cnt == LAST_D :
               (r_state == GAP)  ? r_cnt == LAST_G : 1'b0;

   always_ff @(posedge clk or negedge reset)
      if (!reset) r_state <= IDLE;
      else r_state <= w_next;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = w_valid ? PRE : IDLE;
         PRE:     w_next = w_last ? DATA : PRE;
         DATA:    w_next = w_last ? TRL : DATA;
         TRL:     w_next = w_last ? ((GAP_CYC == 0) ? IDLE : GAP) : TRL;
         GAP:     w_next = w_last ? IDLE : GAP;
         default: w_next = IDLE;
      endcase
   end

   // Counter restarts on every state change so each phase counts from zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt    <= '0;
         r_shreg  <= '0;
         r_rr_ptr <= '0;
         r_grant  <= '0;
         r_done   <= 1'b0;
      end else begin
         r_cnt   <= (r_state == IDLE || r_state != w_next) ? '0 : r_cnt + 1'b1;
         r_grant <= '0;
         r_done  <= r_state == TRL && w_last;
         if (r_state == IDLE && w_valid) begin
            r_shreg  <= data[int'(w_idx)*DATA_W +: DATA_W];
            r_grant  <= w_onehot;
            r_rr_ptr <= (w_idx == IW'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
         end else if (r_state == DATA) begin
            r_shreg <= r_shreg >> 1;
         end
      end
   end

   always_comb begin
      g    = (r_state == PRE)  ? PREAMBLE[r_cnt[1:0]] :
             (r_state == DATA) ? {1'b0, r_shreg[0]} :
             (r_state == TRL)  ? TRAILER[r_cnt[1:0]] : SYM_ZERO;
      busy = r_state != IDLE;
   end

   assign grant = r_grant;
   assign done  = r_done;
endmodule

// File: tb/tb_frame_tx_scheduler.sv
// tb_frame_tx_scheduler: directed frame vectors plus hand-written arbitration
// and mid-frame reset sequences for frame_tx_scheduler.
module tb_frame_tx_scheduler;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  req = '0;
   logic [31:0] data = '0;
   logic [3:0]  grant;
   logic        done, busy;
   logic [1:0]  g;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   frame_tx_scheduler #(.N_REQ(4), .DATA_W(8), .GAP_CYC(2)) dut (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .data  (data),
      .grant (grant),
      .done  (done),
      .busy  (busy),
      .g     (g)
   );

   typedef struct packed {
      logic [3:0]  req;
      logic [31:0] data;
      logic [3:0]  grant;
      logic [7:0]  payload;
   } vec_t;
   vec_t vecs [5];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   function automatic logic [1:0] exp_sym(input int c, input logic [7:0] p);
      if (c == 1) return 2'b01;
      if (c >= 5 && c <= 12) return {1'b0, p[c-5]};
      if (c == 13 || c == 16) return 2'b11;
      return 2'b00;
   endfunction

   // Called at a negedge while idle; returns at the negedge of cycle 19 (idle again).
   task automatic run_frame(input vec_t v, input int idx);
      req  = v.req;
      data = v.data;
      @(posedge clk);
      @(negedge clk);
      for (int c = 1; c <= 19; c++) begin
         chk($sformatf("v%0d g c%0d", idx, c), 32'(g), 32'(exp_sym(c, v.payload)));
         chk($sformatf("v%0d grant c%0d", idx, c), 32'(grant), (c == 1) ? 32'(v.grant) : 32'd0);
         chk($sformatf("v%0d done c%0d", idx, c), 32'(done), 32'(c == 17));
         chk($sformatf("v%0d busy c%0d", idx, c), 32'(busy), 32'(c <= 18));
         if (c == 1) begin
            req  = '0;
            data = ~v.data;
         end
         if (c < 19) @(negedge clk);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      req   = '0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      int n;
      int starts [8];
      logic [3:0] grants [8];
      vecs[0] = '{req: 4'b0100, data: 32'h11A52233, grant: 4'b0100, payload: 8'hA5};
      vecs[1] = '{req: 4'b0011, data: 32'h77665500, grant: 4'b0001, payload: 8'h00};
      vecs[2] = '{req: 4'b0011, data: 32'h1234FF56, grant: 4'b0010, payload: 8'hFF};
      vecs[3] = '{req: 4'b1001, data: 32'h3C00AA99, grant: 4'b1000, payload: 8'h3C};
      vecs[4] = '{req: 4'b1010, data: 32'h5A008100, grant: 4'b0010, payload: 8'h81};

      #1 chk("in reset", 32'({g, busy, grant, done}), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         chk($sformatf("idle c%0d", i), 32'({g, busy, grant, done}), 32'd0);
      end

      for (int i = 0; i < 5; i++) run_frame(vecs[i], i);

      // All requesters held: grants rotate 0,1,2,3,0 every 19 cycles.
      do_reset();
      req = 4'b1111;
      n = 0;
      for (int c = 1; c <= 90; c++) begin
         @(negedge clk);
         if (grant != 0 && n < 8) begin
            starts[n] = c;
            grants[n] = grant;
            n++;
         end
      end
      chk("rr grant count", 32'(n), 32'd5);
      for (int k = 0; k < 5 && k < n; k++) begin
         chk($sformatf("rr grant %0d", k), 32'(grants[k]), 32'(4'b0001 << (k % 4)));
         chk($sformatf("rr start %0d", k), 32'(starts[k]), 32'(1 + 19 * k));
      end

      // Request change while busy has no effect until the next idle.
      do_reset();
      req = 4'b0001;
      for (int c = 1; c <= 25; c++) begin
         @(negedge clk);
         chk($sformatf("late req grant c%0d", c), 32'(grant),
             (c == 1) ? 32'd1 : (c == 20) ? 32'd2 : 32'd0);
         if (c == 5) req = 4'b0010;
      end

      // Reset mid-DATA aborts the frame and restarts arbitration at requester 0.
      do_reset();
      req = 4'b0001;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c == 1) req = '0;
      end
      chk("abort pre busy", 32'(busy), 32'd1);
      reset = 1'b0;
      #1 chk("abort outputs", 32'({g, busy, grant, done}), 32'd0);
      req = 4'b1001;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("abort hold c%0d", c), 32'({g, busy, grant, done}), 32'd0);
      end
      reset = 1'b1;
      @(negedge clk);
      chk("restart grant", 32'(grant), 32'd1);
      chk("restart g", 32'(g), 32'd1);
      req = '0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
